// File: rtl/counter_sequencer_if.sv
// Requester-side job handshake shared by two requesters; requester i uses bit i
// and data lane [i*N +: N].
interface counter_sequencer_if #(
   parameter int N = 64
);
   logic [1:0]     req_valid;
   logic [1:0]     req_ready;
   logic [1:0]     req_dec;
   logic [2*N-1:0] req_start;
   logic [2*N-1:0] req_target;

   modport master (
      output req_valid, req_start, req_target, req_dec,
      input  req_ready
   );

   modport slave (
      input  req_valid, req_start, req_target, req_dec,
      output req_ready
   );
endinterface

// File: rtl/counter_sequencer.sv
// Round-robin sequencer that shares one external up/down loadable counter
// between two requesters and stops it exactly at each job's target.
module counter_sequencer #(
   parameter int N = 64
) (
   input  logic                clock,
   input  logic                reset,
   counter_sequencer_if.slave  req,
   input  logic                pause,
   input  logic                abort,
   input  logic [N-1:0]        cnt_value,
   output logic                cnt_load,
   output logic [N-1:0]        cnt_load_value,
   output logic                cnt_enable,
   output logic                cnt_dec,
   output logic                busy,
   output logic                done,
   output logic                done_id,
   output logic                done_abort
);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      RUN,
      DONE
   } state_t;

   state_t       state;
   logic         rr_ptr;
   logic         id_q;
   logic         dec_q;
   logic         abort_q;
   logic [N-1:0] start_q;
   logic [N-1:0] target_q;

   logic         grant;
   logic [1:0]   ready;
   logic         handshake;
   logic         at_target;

   // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
   always_comb begin
      grant = rr_ptr;
      if (req.req_valid == 2'b01) grant = 1'b0;
      else if (req.req_valid == 2'b10) grant = 1'b1;
      ready = 2'b00;
      // Ready is combinational, so it is gated by reset to stay low while reset is held.
      if (state == IDLE && reset && req.req_valid != 2'b00) ready[grant] = 1'b1;
   end

   assign req.req_ready = ready;
   assign handshake     = |(req.req_valid & ready);
   assign at_target     = (cnt_value == target_q);

   // NOTE: sequential state uses non-blocking assignments only; blocking here would race with readers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         rr_ptr   <= 1'b0;
         id_q     <= 1'b0;
         dec_q    <= 1'b0;
         abort_q  <= 1'b0;
         start_q  <= '0;
         target_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (handshake) begin
                  start_q  <= grant ? req.req_start[N +: N]  : req.req_start[0 +: N];
                  target_q <= grant ? req.req_target[N +: N] : req.req_target[0 +: N];
                  dec_q    <= req.req_dec[grant];
                  id_q     <= grant;
                  abort_q  <= 1'b0;
                  state    <= LOAD;
               end
            end
            LOAD: begin
               // An abort here skips RUN, but the load strobe has already gone out this cycle.
               abort_q <= abort;
               state   <= abort ? DONE : RUN;
            end
            RUN: begin
               if (at_target) begin
                  abort_q <= 1'b0;
                  state   <= DONE;
               end else if (abort) begin
                  abort_q <= 1'b1;
                  state   <= DONE;
               end
            end
            DONE: begin
               rr_ptr <= ~id_q;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign cnt_load       = (state == LOAD);
   assign cnt_load_value = start_q;
   assign cnt_enable     = (state == RUN) & ~pause & ~at_target & ~abort;
   assign cnt_dec        = (state == RUN) & dec_q;
   assign busy           = (state != IDLE);
   assign done           = (state == DONE);
   assign done_id        = done & id_q;
   assign done_abort     = done & abort_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer with N=8: a behavioural counter closes the
// loop, and per-job expectations are queued at handshake and checked at done.
module tb_counter_sequencer;

   localparam int N = 8;

   typedef struct {
      logic       id;
      logic       ab;
      logic [7:0] fin;
      int         en;
      int         lat;
   } exp_t;

   logic         clock = 1'b0;
   logic         reset = 1'b0;
   logic         cnt_rst_n = 1'b0;
   logic         pause = 1'b0;
   logic         abort = 1'b0;
   logic [N-1:0] cnt_value;
   logic         cnt_load;
   logic [N-1:0] cnt_load_value;
   logic         cnt_enable;
   logic         cnt_dec;
   logic         busy;
   logic         done;
   logic         done_id;
   logic         done_abort;

   int   n_tests = 0;
   int   n_fail  = 0;
   logic exp_rr  = 1'b0;
   exp_t sb[$];

   counter_sequencer_if #(.N(N)) req_bus ();

   counter_sequencer #(.N(N)) dut (
      .clock          (clock),
      .reset          (reset),
      .req            (req_bus.slave),
      .pause          (pause),
      .abort          (abort),
      .cnt_value      (cnt_value),
      .cnt_load       (cnt_load),
      .cnt_load_value (cnt_load_value),
      .cnt_enable     (cnt_enable),
      .cnt_dec        (cnt_dec),
      .busy           (busy),
      .done           (done),
      .done_id        (done_id),
      .done_abort     (done_abort)
   );

   always #5 clock = ~clock;

   // Shared counter with its own reset, wrapping modulo 2^N.
   always @(posedge clock or negedge cnt_rst_n) begin
      if (!cnt_rst_n)     cnt_value <= '0;
      else if (cnt_load)  cnt_value <= cnt_load_value;
      else if (cnt_enable) cnt_value <= cnt_dec ? cnt_value - 8'd1 : cnt_value + 8'd1;
   end

   initial begin
      #200_000;
      $display("FAIL watchdog: simulation time limit reached, observed hang expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expd);
      n_tests++;
      assert (obs === expd) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expd);
      end
   endtask

   function automatic int steps_to(input logic [7:0] from, input logic [7:0] to, input logic dc);
      logic [7:0] d;
      d = dc ? from - to : to - from;
      return int'(d);
   endfunction

   // One job from handshake to done; pv/pn pause at a count, av aborts at a count.
   task automatic do_job(input logic id, input logic both, input logic [7:0] st,
                         input logic [7:0] tg, input logic dc, input logic [7:0] pv,
                         input int pn, input logic ab_en, input logic [7:0] av,
                         input logic load_abort);
      exp_t e, g;
      logic win, got;
      int   k, lim, p, n, en_cnt, pause_left;

      @(negedge clock);
      req_bus.req_valid  = both ? 2'b11 : (2'b01 << id);
      req_bus.req_start  = {st, st};
      req_bus.req_target = {tg, tg};
      req_bus.req_dec    = {dc, dc};
      #1;
      win = both ? exp_rr : id;
      check("grant_ready", req_bus.req_ready, 2'b01 << win);

      k = steps_to(st, tg, dc);
      e.id = win;
      if (load_abort) begin
         e.ab = 1'b1; e.fin = st; e.en = 0; e.lat = 2;
      end else begin
         e.ab = ab_en && (steps_to(st, av, dc) < k);
         lim  = e.ab ? steps_to(st, av, dc) : k;
         p    = (pn > 0 && steps_to(st, pv, dc) < lim) ? pn : 0;
         e.fin = e.ab ? av : tg;
         e.en  = lim;
         e.lat = 3 + lim + p;
      end
      @(posedge clock);
      sb.push_back(e);

      @(negedge clock);
      n = 1;
      if (load_abort) abort = 1'b1;
      if (!both) req_bus.req_valid = 2'b00;
      #1;
      check("load_strobe", cnt_load, 1'b1);
      check("load_value", cnt_load_value, st);
      check("load_no_enable", cnt_enable, 1'b0);
      check("ready_busy", req_bus.req_ready, 2'b00);

      got = 1'b0; en_cnt = 0; pause_left = pn;
      while (!got && n < 600) begin
         @(negedge clock);
         n++;
         abort = 1'b0;
         pause = 1'b0;
         if (cnt_value == pv && pause_left > 0) begin
            pause = 1'b1;
            pause_left--;
         end
         if (ab_en && cnt_value == av) abort = 1'b1;
         #1;
         if (cnt_enable) en_cnt++;
         if (pause || (abort && cnt_value != tg)) check("hold_enable", cnt_enable, 1'b0);
         check("ready_busy", req_bus.req_ready, 2'b00);
         if (done) got = 1'b1;
      end
      check("done_seen", got, 1'b1);
      if (got && sb.size() > 0) begin
         g = sb.pop_front();
         check("done_id", done_id, g.id);
         check("done_abort", done_abort, g.ab);
         check("final_value", cnt_value, g.fin);
         check("enable_cycles", en_cnt, g.en);
         check("done_latency", n, g.lat);
         check("busy_in_done", busy, 1'b1);
         exp_rr = ~g.id;
      end
      abort = 1'b0;
      pause = 1'b0;
   endtask

   initial begin
      req_bus.req_valid  = 2'b00;
      req_bus.req_start  = '0;
      req_bus.req_target = '0;
      req_bus.req_dec    = 2'b00;
      repeat (3) @(negedge clock);
      #1;
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_load", cnt_load, 1'b0);
      check("rst_enable", cnt_enable, 1'b0);
      check("rst_load_value", cnt_load_value, 8'h00);
      check("rst_done_flags", {done_id, done_abort, cnt_dec}, 3'b000);
      reset = 1'b1;
      cnt_rst_n = 1'b1;

      // Basic up count and wrapping down count
      do_job(1'b0, 1'b0, 8'h10, 8'h14, 1'b0, 8'h00, 0, 1'b0, 8'h00, 1'b0);
      do_job(1'b1, 1'b0, 8'h02, 8'hFE, 1'b1, 8'h00, 0, 1'b0, 8'h00, 1'b0);

      // Both requesters held valid: alternating grants
      repeat (4) do_job(1'b0, 1'b1, 8'h05, 8'h07, 1'b0, 8'h00, 0, 1'b0, 8'h00, 1'b0);
      req_bus.req_valid = 2'b00;

      // Pause, abort mid-run, abort at target, abort during load
      do_job(1'b0, 1'b0, 8'h10, 8'h14, 1'b0, 8'h12, 3, 1'b0, 8'h00, 1'b0);
      do_job(1'b1, 1'b0, 8'h10, 8'h14, 1'b0, 8'h00, 0, 1'b1, 8'h12, 1'b0);
      do_job(1'b0, 1'b0, 8'h10, 8'h14, 1'b0, 8'h00, 0, 1'b1, 8'h14, 1'b0);
      do_job(1'b1, 1'b0, 8'h40, 8'h50, 1'b0, 8'h00, 0, 1'b0, 8'h00, 1'b1);

      // Zero-length job
      do_job(1'b0, 1'b0, 8'h33, 8'h33, 1'b0, 8'h00, 0, 1'b0, 8'h00, 1'b0);

      // Reset in the middle of RUN
      @(negedge clock);
      req_bus.req_valid  = 2'b01;
      req_bus.req_start  = {8'h00, 8'h00};
      req_bus.req_target = {8'h80, 8'h80};
      req_bus.req_dec    = 2'b00;
      @(posedge clock);
      @(negedge clock);
      req_bus.req_valid = 2'b00;
      repeat (4) @(negedge clock);
      #1;
      check("pre_reset_enable", cnt_enable, 1'b1);
      req_bus.req_valid = 2'b11;
      reset = 1'b0;
      #1;
      check("async_rst_enable", cnt_enable, 1'b0);
      check("async_rst_busy", busy, 1'b0);
      check("async_rst_ready", req_bus.req_ready, 2'b00);
      check("async_rst_load", cnt_load, 1'b0);
      @(negedge clock);
      reset = 1'b1;
      #1;
      check("post_rst_busy", busy, 1'b0);
      check("post_rst_rr_ptr", req_bus.req_ready, 2'b01);
      req_bus.req_valid = 2'b00;
      exp_rr = 1'b0;

      // Normal operation after recovery
      do_job(1'b1, 1'b0, 8'h20, 8'h22, 1'b0, 8'h00, 0, 1'b0, 8'h00, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
- Controller that shares one N-bit up/down loadable counter between two requesters.
- Each requester submits a job {start value, target value, direction} over a valid/ready handshake.
- The sequencer arbitrates between requesters round-robin, then drives the counter's load/enable/dec inputs.
- It stops the counter exactly at the target and reports completion with a one-cycle done pulse.

Parameters:
N, 64, counter width in bits (matches the counter's data width).

Ports:
clock  input  1  single system clock, rising edge
reset  input  1  asynchronous, active-low reset
req_valid  input  2  per-requester job valid (bit i = requester i)
req_ready  output  2  per-requester accept; at most one bit high
req_start  input  2*N  start values, requester i in bits [i*N +: N]
req_target  input  2*N  target values, same packing
req_dec  input  2  direction per requester: 1 = count down, 0 = count up
pause  input  1  while high in RUN, counter enable is held low
abort  input  1  terminates the active job
cnt_value  input  N  current counter output
cnt_load  output  1  counter load strobe
cnt_load_value  output  N  value to load
cnt_enable  output  1  counter enable
cnt_dec  output  1  counter direction
busy  output  1  high in LOAD, RUN and DONE
done  output  1  one-cycle completion pulse
done_id  output  1  requester index of the finished job, valid with done
done_abort  output  1  job ended by abort, valid with done

Behaviour:
- Reset (reset low, asynchronous): state=IDLE, rr_ptr=0, all outputs 0, latched job registers 0.
- Reset deasserted mid-operation: the sequencer restarts in IDLE. The counter's own reset is independent.
- IDLE state:
  - req_ready[g]=1 combinationally for the winner g among asserted req_valid bits.
  - Winner when both are valid: g=rr_ptr. Otherwise g is the only valid requester.
  - Handshake = req_valid[g] & req_ready[g] in the same cycle. On handshake, latch start, target, dec and id=g; next state LOAD.
  - req_ready=0 in every state other than IDLE.
- LOAD state (exactly 1 cycle):
  - cnt_load=1, cnt_load_value=latched start, cnt_enable=0.
  - Next state RUN.
- RUN state:
  - cnt_dec = latched dec.
  - cnt_enable = ~pause & (cnt_value != target) & ~abort.
  - If cnt_value == target: next state DONE with done_abort=0. Target match has priority over abort in the same cycle.
  - Else if abort: next state DONE with done_abort=1.
  - pause does not block the target compare.
- Arithmetic and cycle count:
  - The counter wraps modulo 2^N.
  - Steps k = (target-start) mod 2^N for up, (start-target) mod 2^N for down.
  - RUN lasts k+1+P cycles, where P is the number of paused cycles.
- DONE state (1 cycle):
  - done=1, done_id=id, done_abort set as above.
  - rr_ptr <= ~id.
  - Next state IDLE.
- abort in IDLE or DONE is ignored. abort in LOAD moves to DONE with done_abort=1, and the load still occurs.
- A requester that deasserts req_valid before the handshake is simply not granted; no penalty.
- Latency, no pause, handshake in cycle T0: LOAD at T1, RUN from T2 to T2+k, done at T3+k.

Test Plan:
1. N=8, req0 start=0x10 target=0x14 dec=0, handshake at T0 -> cnt_load=1 with 0x10 at T1; cnt_enable high T2..T5 (4 cycles); cnt_value=0x14 at T6; done=1, done_id=0, done_abort=0 at T7.
2. req1 start=0x02 target=0xFE dec=1 -> cnt_value passes 0x01, 0x00, 0xFF, 0xFE; exactly 4 enable cycles; done_id=1.
3. Both req_valid held high for 4 jobs after reset -> grant order 0,1,0,1; req_ready never has both bits high.
4. Job 0x10->0x14 with pause high for 3 cycles at count 0x12 -> cnt_enable low and cnt_value held at 0x12 for 3 cycles; done at T10.
5. abort at count 0x12 -> cnt_enable low that cycle; done with done_abort=1 next cycle; counter holds 0x12. Also: abort in the same cycle cnt_value==target -> done_abort=0.
6. start=target=0x33 -> cnt_enable never asserted, done at T3. Separately, reset asserted mid-RUN -> cnt_enable, busy and req_ready drop immediately (asynchronously); after release, state IDLE and rr_ptr=0.
